srio_link_status_monitor: RTL

//  Tracks bring-up of NUM_PORTS SRIO ports from their raw status bits (port_initialized,

---
 rtl/srio_link_status_monitor.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/srio_link_status_monitor.sv
// rtl/srio_link_status_monitor.sv - per-port SRIO bring-up monitor with timeout, drop counters and LEDs
//
// Purpose: synchronises raw SRIO port/link status bits, runs one bring-up FSM per port
//          (S_DOWN, S_PORT, S_UP, S_FAIL), enforces an init timeout, counts link drops
//          and produces event pulses plus per-port LED nibbles.
// Optional feature macro: LINK_DEBOUNCE_EN (per-bit debounce filter after the synchroniser).
// Ports:
//   sys_clk, sys_rst          clock, asynchronous active-high reset
//   port_init_i, link_init_i  raw status per port (asynchronous)
//   mode_1x_i                 raw 1x-mode indication per port (asynchronous)
//   clr_stats                 synchronous pulse: clear drop counters, release S_FAIL
//   state_o                   per-port FSM state, port p at [2p+1:2p]
//   link_up_o, all_up_o       per-port S_UP flag, registered AND of all ports
//   up_pulse_o, drop_pulse_o, tmo_pulse_o  one-cycle event pulses per port
//   drop_cnt_o                saturating drop counters, port p at [CNT_W*p +: CNT_W]
//   led_o                     per port {link_up, link_init, port_init, ~mode_1x}
module srio_link_status_monitor #(
    parameter int NUM_PORTS    = 2,
    parameter int INIT_TIMEOUT = 4096,
    parameter int CNT_W        = 8,
    parameter int DEBOUNCE_CYC = 8
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [NUM_PORTS-1:0]       port_init_i,
    input  logic [NUM_PORTS-1:0]       link_init_i,
    input  logic [NUM_PORTS-1:0]       mode_1x_i,
    input  logic                       clr_stats,
    output logic [2*NUM_PORTS-1:0]     state_o,
    output logic [NUM_PORTS-1:0]       link_up_o,
    output logic                       all_up_o,
    output logic [NUM_PORTS-1:0]       up_pulse_o,
    output logic [NUM_PORTS-1:0]       drop_pulse_o,
    output logic [NUM_PORTS-1:0]       tmo_pulse_o,
    output logic [CNT_W*NUM_PORTS-1:0] drop_cnt_o,
    output logic [4*NUM_PORTS-1:0]     led_o
);

    localparam int TW = $clog2(INIT_TIMEOUT);
    localparam int NB = 3 * NUM_PORTS;
    localparam logic [TW-1:0]    TMO_LAST = TW'(INIT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_DOWN = 2'd0,
        S_PORT = 2'd1,
        S_UP   = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    // Raw inputs packed as {mode, link, port} so one synchroniser/filter serves all bits.
    logic [NB-1:0] raw_bits, sync1, sync2, filt;
    assign raw_bits = {mode_1x_i, link_init_i, port_init_i};

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_bits;
            sync2 <= sync1;
        end
    end

`ifdef LINK_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    logic [DW-1:0] db_cnt [NB];

    // Filter flips only after DEBOUNCE_CYC consecutive samples that disagree with it;
    // any agreeing sample restarts the run, so shorter glitches are swallowed.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            filt <= '0;
            for (int b = 0; b < NB; b++) db_cnt[b] <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (sync2[b] == filt[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == DW'(DEBOUNCE_CYC - 1)) begin
                    filt[b]   <= sync2[b];
                    db_cnt[b] <= '0;
                end else begin
                    db_cnt[b] <= db_cnt[b] + DW'(1);
                end
            end
        end
    end
`else
    assign filt = sync2;
`endif

    logic [NUM_PORTS-1:0] fp, fl, fm;
    assign fp = filt[NUM_PORTS-1:0];
    assign fl = filt[2*NUM_PORTS-1:NUM_PORTS];
    assign fm = filt[3*NUM_PORTS-1:2*NUM_PORTS];

    state_t            state    [NUM_PORTS];
    state_t            state_nx [NUM_PORTS];
    logic [TW-1:0]     timer    [NUM_PORTS];
    logic [TW-1:0]     timer_nx [NUM_PORTS];
    logic [CNT_W-1:0]  cnt      [NUM_PORTS];
    logic [CNT_W-1:0]  cnt_nx   [NUM_PORTS];
    logic [NUM_PORTS-1:0]   up_nx, drop_nx, tmo_nx, link_nx;
    logic [4*NUM_PORTS-1:0] led_nx;

    always_comb begin
        up_nx   = '0;
        drop_nx = '0;
        tmo_nx  = '0;
        link_nx = '0;
        led_nx  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            state_nx[p] = state[p];
            timer_nx[p] = timer[p];
            cnt_nx[p]   = cnt[p];
            case (state[p])
                S_DOWN: begin
                    // Progress is checked before expiry, so a late port_init still wins.
                    if (fp[p]) begin
                        state_nx[p] = S_PORT;
                    end else if (timer[p] == TMO_LAST) begin
                        state_nx[p] = S_FAIL;
                        tmo_nx[p]   = 1'b1;
                        timer_nx[p] = '0;
                    end else begin
                        timer_nx[p] = timer[p] + TW'(1);
                    end
                end
                S_PORT: begin
                    // The timer keeps running from S_DOWN entry; S_PORT does not restart it.
                    if (!fp[p]) begin
                        state_nx[p] = S_DOWN;
                        timer_nx[p] = '0;
                    end else if (fl[p]) begin
                        state_nx[p] = S_UP;
                        up_nx[p]    = 1'b1;
                        timer_nx[p] = '0;
                    end else if (timer[p] == TMO_LAST) begin
                        state_nx[p] = S_FAIL;
                        tmo_nx[p]   = 1'b1;
                        timer_nx[p] = '0;
                    end else begin
                        timer_nx[p] = timer[p] + TW'(1);
                    end
                end
                S_UP: begin
                    timer_nx[p] = '0;
                    if (!fp[p] || !fl[p]) begin
                        state_nx[p] = S_DOWN;
                        drop_nx[p]  = 1'b1;
                    end
                end
                default: begin
                    timer_nx[p] = '0;
                    if (fp[p] && fl[p]) begin
                        state_nx[p] = S_UP;
                        up_nx[p]    = 1'b1;
                    end else if (clr_stats) begin
                        state_nx[p] = S_DOWN;
                    end
                end
            endcase
            // A drop coinciding with a clear is counted after the clear.
            if (clr_stats) begin
                cnt_nx[p] = drop_nx[p] ? CNT_W'(1) : '0;
            end else if (drop_nx[p] && cnt[p] != CNT_MAX) begin
                cnt_nx[p] = cnt[p] + CNT_W'(1);
            end
            link_nx[p]         = (state_nx[p] == S_UP);
            led_nx[4*p +: 4]   = {link_nx[p], fl[p], fp[p], ~fm[p]};
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                state[p] <= S_DOWN;
                timer[p] <= '0;
                cnt[p]   <= '0;
            end
            up_pulse_o   <= '0;
            drop_pulse_o <= '0;
            tmo_pulse_o  <= '0;
            link_up_o    <= '0;
            led_o        <= '0;
            all_up_o     <= 1'b0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                state[p] <= state_nx[p];
                timer[p] <= timer_nx[p];
                cnt[p]   <= cnt_nx[p];
            end
            up_pulse_o   <= up_nx;
            drop_pulse_o <= drop_nx;
            tmo_pulse_o  <= tmo_nx;
            link_up_o    <= link_nx;
            led_o        <= led_nx;
            all_up_o     <= &link_up_o;
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_out
        assign state_o[2*g +: 2]        = state[g];
        assign drop_cnt_o[CNT_W*g +: CNT_W] = cnt[g];
    end

endmodule
